// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared constants and types for the multi-cycle RV32I control path:
//   - major opcode constants for the supported instruction classes
//   - ALU operation selects driven on alu_op
//   - state encoding (also visible on the debug 'state' output)
//   - opcode class enum plus the opcode -> class decoder
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_WB     = ST_WB,
    S_TRAP   = ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  // Map a major opcode onto its instruction class; anything unsupported is illegal.
  function automatic op_class_t classify(input logic [6:0] op);
    op_class_t cls;
    case (op)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// 8-bit wait counter shared by the FETCH and MEM handshakes.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : return the count to zero
//   count_en  : a wait cycle (ready low) is in progress
//   limit     : number of consecutive waits allowed (1..255)
//   expired   : this cycle is the limit-th wait with ready still low
// ---------------------------------------------------------------------------
module mem_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       count_en,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_r;

  // Wait-cycle counter; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (count_en) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // The count reaches 'limit' with this cycle's wait, so the limit is hit now.
  // A ready in this same cycle drops count_en and therefore wins.
  assign expired = count_en && (count_r == (limit - 8'd1));

endmodule

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
// Multi-cycle control FSM for the RV32I core: FETCH -> DECODE -> EXEC ->
// [MEM] -> [WB], one instruction at a time, with a sticky TRAP state for
// illegal opcodes and memory handshake timeouts.
// Parameters:
//   MEM_TIMEOUT : wait cycles allowed on imem_ready/dmem_ready (1..255)
//   CNT_W       : width of the retired-instruction counter
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   opcode                 : instr[6:0], sampled in DECODE
//   zero                   : ALU zero flag, used in EXEC for branches
//   imem_ready, dmem_ready : memory handshakes (FETCH / MEM only)
//   imem_req, ir_write, pc_write, pc_src            : fetch / PC control
//   dmem_req, mem_read, mem_write                   : data memory control
//   alu_src, alu_op, reg_write, mem_to_reg          : datapath control
//   trap, trap_cause       : sticky trap flag, 0 illegal / 1 timeout
//   state                  : current state for debug
//   retired                : retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_sequencer
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             dmem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             trap,
  output logic             trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_t          state_r;
  op_class_t       cls_r;
  logic            cause_r;
  logic [CNT_W-1:0] retired_r;

  logic ready_sel_s;
  logic wait_count_s;
  logic timed_out_s;

  // Only the handshake belonging to the current state matters.
  assign ready_sel_s  = (state_r == S_FETCH) ? imem_ready : dmem_ready;
  assign wait_count_s = ((state_r == S_FETCH) || (state_r == S_MEM)) && !ready_sel_s;

  // Clearing whenever we are not actively waiting leaves the count at zero on
  // every entry to FETCH or MEM, including MEM -> FETCH on a store retire.
  mem_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!wait_count_s),
    .count_en (wait_count_s),
    .limit    (TIMEOUT_LIMIT),
    .expired  (timed_out_s)
  );

  // Next-state process: state, registered opcode class, trap cause, retire count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_FETCH;
      cls_r     <= CLS_R;
      cause_r   <= 1'b0;
      retired_r <= '0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (imem_ready) begin
            state_r <= S_DECODE;
          end else if (timed_out_s) begin
            state_r <= S_TRAP;
            cause_r <= 1'b1;
          end
        end
        S_DECODE: begin
          cls_r <= classify(opcode);
          if (classify(opcode) == CLS_ILLEGAL) begin
            state_r <= S_TRAP;
            cause_r <= 1'b0;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_r)
            CLS_BRANCH: begin
              state_r   <= S_FETCH;
              retired_r <= retired_r + CNT_W'(1'b1);
            end
            CLS_LOAD, CLS_STORE: state_r <= S_MEM;
            default:             state_r <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (cls_r == CLS_LOAD) begin
              state_r <= S_WB;
            end else begin
              state_r   <= S_FETCH;
              retired_r <= retired_r + CNT_W'(1'b1);
            end
          end else if (timed_out_s) begin
            state_r <= S_TRAP;
            cause_r <= 1'b1;
          end
        end
        S_WB: begin
          state_r   <= S_FETCH;
          retired_r <= retired_r + CNT_W'(1'b1);
        end
        S_TRAP: state_r <= S_TRAP;
        // Unused encodings are treated as a fault and parked in TRAP.
        default: state_r <= S_TRAP;
      endcase
    end
  end

  // Output decode: Moore on state/class, plus the FETCH and branch exceptions.
  // Everything is forced low while rst is held so nothing leaks mid-reset.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    dmem_req   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    trap       = 1'b0;
    trap_cause = 1'b0;
    if (rst) begin
      imem_req = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        S_EXEC: begin
          case (cls_r)
            CLS_R: begin
              alu_src = 1'b0;
              alu_op  = ALUOP_FUNCT;
            end
            CLS_I: begin
              alu_src = 1'b1;
              alu_op  = ALUOP_FUNCT;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_src = 1'b1;
              alu_op  = ALUOP_ADD;
            end
            CLS_BRANCH: begin
              alu_src  = 1'b0;
              alu_op   = ALUOP_SUB;
              pc_write = zero;
              pc_src   = zero;
            end
            default: alu_op = ALUOP_ADD;
          endcase
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          mem_read  = (cls_r == CLS_LOAD);
          mem_write = (cls_r == CLS_STORE);
          alu_src   = 1'b1;
          alu_op    = ALUOP_ADD;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_r == CLS_LOAD);
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_r;
        end
        default: trap = 1'b0;
      endcase
    end
  end

  assign state   = state_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam int TO = 15;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [6:0]    opcode;
  logic          zero;
  logic          imem_ready;
  logic          dmem_ready;
  logic          imem_req, ir_write, pc_write, pc_src, dmem_req, mem_read, mem_write;
  logic          alu_src, reg_write, mem_to_reg, trap, trap_cause;
  logic [1:0]    alu_op;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .dmem_req(dmem_req), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .trap(trap), .trap_cause(trap_cause), .state(state), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_write, pc_write, pc_src, alu_src;
    logic [1:0] alu_op;
    logic       dmem_req, mem_read, mem_write, reg_write, mem_to_reg, trap, trap_cause;
  } obs_t;

  int   errors = 0;
  int   checks = 0;
  int   exp_retired = 0;
  obs_t exp_q[$];
  int   fetch_len, mem_start, mem_len;
  bit   retires;

  // Instruction class from the ISA table: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 illegal.
  function automatic int class_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 5;
    endcase
  endfunction

  function automatic obs_t obs_now();
    obs_t o;
    o.st = state; o.imem_req = imem_req; o.ir_write = ir_write; o.pc_write = pc_write;
    o.pc_src = pc_src; o.alu_src = alu_src; o.alu_op = alu_op; o.dmem_req = dmem_req;
    o.mem_read = mem_read; o.mem_write = mem_write; o.reg_write = reg_write;
    o.mem_to_reg = mem_to_reg; o.trap = trap; o.trap_cause = trap_cause;
    return o;
  endfunction

  task automatic push_trap(input logic cause);
    obs_t e;
    for (int i = 0; i < 21; i++) begin
      e = '0; e.st = 3'd7; e.trap = 1'b1; e.trap_cause = cause;
      exp_q.push_back(e);
    end
  endtask

  // Reference timeline of one instruction: phases with their lengths and enables.
  task automatic build(input int k, input int wf, input int wm, input logic z);
    obs_t e;
    exp_q.delete();
    retires = 1'b0;
    mem_start = -1;
    mem_len = 0;
    fetch_len = (wf < TO) ? wf + 1 : TO;
    for (int c = 0; c < fetch_len; c++) begin
      e = '0; e.st = 3'd0; e.imem_req = 1'b1;
      if (c == wf) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      exp_q.push_back(e);
    end
    if (wf >= TO) begin push_trap(1'b1); return; end
    e = '0; e.st = 3'd1; exp_q.push_back(e);
    if (k == 5) begin push_trap(1'b0); return; end
    e = '0; e.st = 3'd2;
    case (k)
      0: e.alu_op = 2'b10;
      1: begin e.alu_src = 1'b1; e.alu_op = 2'b10; end
      2, 3: e.alu_src = 1'b1;
      default: begin e.alu_op = 2'b01; e.pc_write = z; e.pc_src = z; end
    endcase
    exp_q.push_back(e);
    if (k == 4) begin retires = 1'b1; return; end
    if (k == 2 || k == 3) begin
      mem_start = exp_q.size();
      mem_len = (wm < TO) ? wm + 1 : TO;
      for (int c = 0; c < mem_len; c++) begin
        e = '0; e.st = 3'd3; e.dmem_req = 1'b1; e.alu_src = 1'b1;
        e.mem_read = (k == 2); e.mem_write = (k == 3);
        exp_q.push_back(e);
      end
      if (wm >= TO) begin push_trap(1'b1); return; end
      if (k == 3) begin retires = 1'b1; return; end
    end
    e = '0; e.st = 3'd4; e.reg_write = 1'b1; e.mem_to_reg = (k == 2);
    exp_q.push_back(e);
    retires = 1'b1;
  endtask

  // Run one instruction starting at a negedge; optionally assert rst after cycle abort_at.
  task automatic run_instr(input string name, input logic [6:0] op, input int wf,
                           input int wm, input logic z, input int abort_at);
    obs_t got;
    build(class_of(op), wf, wm, z);
    for (int c = 0; c < exp_q.size(); c++) begin
      opcode     = (c < fetch_len) ? 7'($urandom) : op;
      imem_ready = (c < fetch_len) ? (c == wf) : 1'($urandom);
      dmem_ready = (c >= mem_start && c < mem_start + mem_len) ? ((c - mem_start) == wm)
                                                             : 1'($urandom);
      zero       = (c == fetch_len + 1) ? z : 1'($urandom);
      #1;
      got = obs_now();
      checks++;
      if (got !== exp_q[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs=%h required=%h", name, c, got, exp_q[c]);
      end
      checks++;
      if (retired !== 4'(exp_retired)) begin
        errors++;
        $display("FAIL %s retired cycle %0d: got %0d required %0d", name, c, retired, exp_retired);
      end
      if (c == abort_at) begin
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs_now() !== '0 || retired !== '0) begin
          errors++;
          $display("FAIL %s abort: outputs=%h retired=%0d required all zero", name, obs_now(), retired);
        end
        exp_retired = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (retires) exp_retired = (exp_retired + 1) % 16;
  endtask

  // Hold reset with active-looking inputs and require every output low.
  task automatic do_reset(input string name);
    rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1; opcode = 7'b0110011;
    #1;
    checks++;
    if (obs_now() !== '0 || retired !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h retired=%0d required all zero", name, obs_now(), retired);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    exp_retired = 0;
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_rtype();
    run_instr("rtype", 7'b0110011, 0, 0, 1'b0, -1);
    run_instr("itype", 7'b0010011, 2, 0, 1'b0, -1);
  endtask

  task automatic test_load_wait();
    run_instr("load_wait", 7'b0000011, 0, 3, 1'b0, -1);
    run_instr("store", 7'b0100011, 1, 0, 1'b0, -1);
  endtask

  task automatic test_branch();
    run_instr("branch_taken", 7'b1100011, 0, 0, 1'b1, -1);
    run_instr("branch_not_taken", 7'b1100011, 0, 0, 1'b0, -1);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 7'b1111111, 0, 0, 1'b0, -1);
    do_reset("illegal_reset");
  endtask

  task automatic test_timeout();
    run_instr("fetch_limit_ready", 7'b0110011, TO - 1, 0, 1'b0, -1);
    run_instr("fetch_timeout", 7'b0110011, TO, 0, 1'b0, -1);
    do_reset("fetch_timeout_reset");
    run_instr("mem_limit_ready", 7'b0000011, 0, TO - 1, 1'b0, -1);
    run_instr("mem_timeout", 7'b0100011, 0, TO, 1'b0, -1);
    do_reset("mem_timeout_reset");
  endtask

  task automatic test_reset_mid_store();
    run_instr("pre_abort", 7'b0110011, 0, 0, 1'b0, -1);
    run_instr("store_abort", 7'b0100011, 0, 8, 1'b0, 5);
    run_instr("post_abort", 7'b0110011, 0, 0, 1'b0, -1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 18; i++)
      run_instr("wrap", 7'b1100011, $urandom_range(0, 2), 0, 1'(i), -1);
  endtask

  task automatic test_random();
    logic [6:0] op;
    int wf, wm;
    logic [6:0] legal [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        op = 7'($urandom);
        while (class_of(op) != 5) op = 7'($urandom);
      end else begin
        op = legal[$urandom_range(0, 4)];
      end
      wf = ($urandom_range(0, 24) == 0) ? TO + 3 : $urandom_range(0, 4);
      wm = ($urandom_range(0, 24) == 0) ? TO + 3 : $urandom_range(0, 4);
      run_instr("random", op, wf, wm, 1'($urandom), -1);
      if (!retires) do_reset("random_reset");
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
